fft_bitrev_buffer: RTL and testbench

FFT_BITREV_BUFFER -- requirements
Module: fft_bitrev_buffer

---
 rtl/fft_bitrev_buffer.sv | 111 +++++++++++
 tb/tb_fft_bitrev_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_buffer.sv
// Bit-reversal reorder buffer for a pipelined FFT: samples arrive in bit-reversed
// order and leave in natural order. Two banks ping-pong: one fills while the other is read.
module fft_bitrev_buffer #(
  parameter int LGSIZE = 12,
  parameter int WIDTH  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_ce,
  input  logic [2*WIDTH-1:0] i_sample,
  input  logic               i_sync,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_sync,
  output logic [1:0]         o_state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [LGSIZE-1:0]   k_q, k_d;
  logic                wb_q, wb_d;
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic                sync_q, sync_d;
  logic                we, rd_en;
  logic [LGSIZE:0]     waddr, raddr;
  logic [LGSIZE-1:0]   k_rev;

  // Bank select is the address MSB: {bank, index}.
  logic [2*WIDTH-1:0]  mem [0:(2**(LGSIZE+1))-1];

  always_comb begin
    k_rev = '0;
    for (int b = 0; b < LGSIZE; b++) k_rev[b] = k_q[LGSIZE-1-b];
  end

  assign raddr = {~wb_q, k_rev};

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wb_d     = wb_q;
    result_d = result_q;
    sync_d   = sync_q;
    we       = 1'b0;
    rd_en    = 1'b0;
    waddr    = {wb_q, k_q};
    if (i_ce) begin
      case (state_q)
        IDLE: begin
          if (i_sync) begin
            we       = 1'b1;
            waddr    = {wb_q, {LGSIZE{1'b0}}};
            k_d      = LGSIZE'(1);
            state_d  = FILL;
            result_d = '0;
            sync_d   = 1'b0;
          end
        end
        default: begin
          we = 1'b1;
          if (i_sync && (k_q != '0)) begin
            // Sync arrived mid-frame: restart the frame in the current bank.
            waddr    = {wb_q, {LGSIZE{1'b0}}};
            k_d      = LGSIZE'(1);
            state_d  = FILL;
            result_d = '0;
            sync_d   = 1'b0;
          end else begin
            k_d = k_q + 1'b1;
            if (k_q == '1) wb_d = ~wb_q;
            if (state_q == RUN) begin
              rd_en  = 1'b1;
              sync_d = (k_q == '0);
            end else begin
              result_d = '0;
              sync_d   = 1'b0;
              if (k_q == '1) state_d = RUN;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      wb_q     <= 1'b0;
      result_q <= '0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wb_q     <= wb_d;
      sync_q   <= sync_d;
      if (rd_en) result_q <= mem[raddr];
      else       result_q <= result_d;
    end
  end

  // Buffer contents are not reset; reads only ever hit the bank not being written.
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= i_sample;
  end

  assign o_result    = result_q;
  assign o_sync      = sync_q;
  assign o_state_dbg = state_q;

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Bench for fft_bitrev_buffer: a small N=8 instance driven with directed frames and
// an N=4096 instance driven with random frames, both checked through expected queues.
module tb_fft_bitrev_buffer;
  localparam int N  = 8;
  localparam int NB = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        ce = 1'b0, sync = 1'b0;
  logic [31:0] smp = '0;
  logic [31:0] res;
  logic        osync;
  logic [1:0]  st;
  logic        ce_b = 1'b0, sync_b = 1'b0;
  logic [31:0] smp_b = '0;
  logic [31:0] res_b;
  logic        osync_b;
  logic [1:0]  st_b;

  fft_bitrev_buffer #(.LGSIZE(3), .WIDTH(16)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_sample(smp), .i_sync(sync),
    .o_result(res), .o_sync(osync), .o_state_dbg(st)
  );

  fft_bitrev_buffer #(.LGSIZE(12), .WIDTH(16)) u_big (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce_b), .i_sample(smp_b), .i_sync(sync_b),
    .o_result(res_b), .o_sync(osync_b), .o_state_dbg(st_b)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_b_q[$];
  logic        seen = 1'b0, seen_b = 1'b0;
  logic [32:0] held = '0, held_b = '0;
  int          rev_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [31:0] prev_f[NB];
  logic [31:0] cur_f[NB];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int brev12(input int v);
    int r = 0;
    for (int b = 0; b < 12; b++) r = r | (((v >> b) & 1) << (11 - b));
    return r;
  endfunction

  // Monitors: a strobe seen at a rising edge makes the next falling edge an output slot.
  always @(posedge clk) begin
    seen   = rst_n && ce;
    seen_b = rst_n && ce_b;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held   = '0;
      held_b = '0;
    end
    if (seen) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_small: got %h expected none", {osync, res});
      end else begin
        held = exp_q.pop_front();
        check("out_small", {osync, res}, held);
      end
    end else check("hold_small", {osync, res}, held);
    if (seen_b) begin
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_big: got %h expected none", {osync_b, res_b});
      end else begin
        held_b = exp_b_q.pop_front();
        check("out_big", {osync_b, res_b}, held_b);
      end
    end else check("hold_big", {osync_b, res_b}, held_b);
  end

  task automatic put(input logic [31:0] d, input logic s, input logic [32:0] e, input int gap);
    repeat (gap) begin
      @(negedge clk); ce = 1'b0; sync = 1'b0;
    end
    @(negedge clk);
    ce = 1'b1; smp = d; sync = s;
    exp_q.push_back(e);
  endtask

  task automatic put_b(input logic [31:0] d, input logic s, input logic [32:0] e);
    @(negedge clk);
    ce_b = 1'b1; smp_b = d; sync_b = s;
    exp_b_q.push_back(e);
  endtask

  task automatic rest(input int n);
    repeat (n) begin
      @(negedge clk);
      ce = 1'b0; sync = 1'b0; ce_b = 1'b0; sync_b = 1'b0;
    end
  endtask

  // One N=8 frame of base+k; when expect_out, the output is the previous frame reordered.
  task automatic frame(input logic [31:0] base, input logic [31:0] pbase,
                       input bit expect_out, input int gap);
    logic [32:0] e;
    for (int k = 0; k < N; k++) begin
      e = expect_out ? {(k == 0), pbase + 32'(rev_tab[k])} : 33'd0;
      put(base + 32'(k), (k == 0), e, gap);
    end
  endtask

  initial begin
    logic [32:0] e;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    check("reset_out", {osync, res}, 33'd0);
    check("reset_state", 33'(st), 33'd0);
    check("reset_out_big", {osync_b, res_b}, 33'd0);
    rst_n = 1'b1;

    // Unsynced samples are dropped, then three synced frames.
    for (int k = 0; k < 5; k++) put(32'h100 + 32'(k), 1'b0, 33'd0, 0);
    frame(32'h10, 32'h0, 1'b0, 0);
    frame(32'h20, 32'h10, 1'b1, 0);
    frame(32'h30, 32'h20, 1'b1, 0);

    // Strobe only every third cycle.
    frame(32'h40, 32'h30, 1'b1, 2);
    frame(32'h50, 32'h40, 1'b1, 2);

    // Resync at k=5 of a running frame.
    for (int k = 0; k < 5; k++) begin
      e = {(k == 0), 32'h50 + 32'(rev_tab[k])};
      put(32'h60 + 32'(k), (k == 0), e, 0);
    end
    put(32'h70, 1'b1, 33'd0, 0);
    for (int k = 1; k < N; k++) put(32'h70 + 32'(k), 1'b0, 33'd0, 0);
    frame(32'h80, 32'h70, 1'b1, 0);

    // Asynchronous reset between edges in mid-frame.
    for (int k = 0; k < 3; k++) begin
      e = {(k == 0), 32'h80 + 32'(rev_tab[k])};
      put(32'h90 + 32'(k), (k == 0), e, 0);
    end
    rest(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", {osync, res}, 33'd0);
    check("async_rst_state", 33'(st), 33'd0);
    rest(2);
    rst_n = 1'b1;
    frame(32'hA0, 32'h0, 1'b0, 0);
    frame(32'hB0, 32'hA0, 1'b1, 0);
    rest(3);
    check("state_run", 33'(st), 33'd2);
    check("drain_small", 33'(exp_q.size()), 33'd0);

    // Large frames with random data, four back to back.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NB; k++) begin
        d = $urandom;
        cur_f[k] = d;
        e = (f == 0) ? 33'd0 : {(k == 0), prev_f[brev12(k)]};
        put_b(d, (k == 0), e);
      end
      for (int k = 0; k < NB; k++) prev_f[k] = cur_f[k];
    end
    rest(3);
    check("drain_big", 33'(exp_b_q.size()), 33'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
